cfg_chain_loader: RTL and testbench

Configuration-chain master that drives the serial config port (CfgMode/CfgClk/CfgShift/CfgDataIn/CfgDataOut) of reconfigurable cells such as the TRFSM-based FSM wrappers. It accepts a bitstream as parallel words over a valid/ready handshake and shifts it LSB-first into the chain. It simultaneously captures the bits falling out of the chain end and returns them as readback words for verification. It sits between the SoC configuration register interface and the chain of reconfigurable blocks.

---
 rtl/cfg_chain_loader_pkg.sv | 22 ++
 rtl/cfg_chain_loader_if.sv | 30 +++
 rtl/cfg_chain_loader_word_shifter.sv | 48 ++++
 rtl/cfg_chain_loader.sv | 111 +++++++++++
 tb/tb_cfg_chain_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package cfg_chain_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int LENGTH_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_FLUSH,
    S_DONE
  } state_t;

  // Number of bitstream words needed to carry len bits.
  function automatic int unsigned ceil_words(input int unsigned len,
                                             input int unsigned width = DATA_WIDTH);
    return (len + width - 1) / width;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host-side word interface of the loader: bitstream in, readback out, status.
interface cfg_chain_loader_if
  import cfg_chain_pkg::*;
#(
  parameter int DataWidth   = DATA_WIDTH,
  parameter int LengthWidth = LENGTH_WIDTH
) ();

  logic                   Start_i;
  logic [LengthWidth-1:0] Length_i;
  logic [DataWidth-1:0]   DataIn_i;
  logic                   DataInValid_i;
  logic                   DataInReady_o;
  logic [DataWidth-1:0]   DataOut_o;
  logic                   DataOutValid_o;
  logic                   DataOutReady_i;
  logic                   Busy_o;
  logic                   Done_o;

  modport master (
    output Start_i, Length_i, DataIn_i, DataInValid_i, DataOutReady_i,
    input  DataInReady_o, DataOut_o, DataOutValid_o, Busy_o, Done_o
  );

  modport slave (
    input  Start_i, Length_i, DataIn_i, DataInValid_i, DataOutReady_i,
    output DataInReady_o, DataOut_o, DataOutValid_o, Busy_o, Done_o
  );

endinterface

// File: rtl/cfg_chain_loader_word_shifter.sv
// Per-word serialiser/deserialiser: TX word read LSB-first, RX word filled LSB-first.
// o_next_bit is the bit the following ShiftLow must present, valid on load or advance.
module cfg_word_shifter
  import cfg_chain_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [DataWidth-1:0] i_word,
  input  logic                 i_capture,
  input  logic                 i_cap_bit,
  input  logic                 i_advance,
  output logic                 o_next_bit,
  output logic                 o_last,
  output logic [DataWidth-1:0] o_rx
);

  localparam int IW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  logic [DataWidth-1:0] r_tx;
  logic [DataWidth-1:0] r_rx;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;

  assign o_last     = (r_idx == IW'(DataWidth - 1));
  assign w_idx_nxt  = o_last ? '0 : r_idx + IW'(1);
  assign o_next_bit = i_load ? i_word[0] : r_tx[w_idx_nxt];
  assign o_rx       = r_rx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      // Clearing RX here leaves unfilled bits of a partial final word at 0.
      r_tx  <= i_word;
      r_rx  <= '0;
      r_idx <= '0;
    end else begin
      if (i_capture) r_rx[r_idx] <= i_cap_bit;
      if (i_advance) r_idx <= w_idx_nxt;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Config-chain master: shifts word-fed bitstream LSB-first into the chain, returns readback words.
// Two Clk_i cycles per bit plus one Fetch and one Flush cycle per word; chain is idle during stalls.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int DataWidth   = DATA_WIDTH,
  parameter int LengthWidth = LENGTH_WIDTH
) (
  input  logic               Clk_i,
  input  logic               Reset_n_i,
  cfg_chain_loader_if.slave  host,
  output logic               CfgMode_o,
  output logic               CfgClk_o,
  output logic               CfgShift_o,
  output logic               CfgDataOut_o,
  input  logic               CfgDataIn_i
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LengthWidth-1:0] r_remaining;
  logic                   r_cfg_mode;
  logic                   r_cfg_clk;
  logic                   r_cfg_shift;
  logic                   r_cfg_dout;
  logic                   w_load;
  logic                   w_capture;
  logic                   w_advance;
  logic                   w_next_bit;
  logic                   w_last;
  logic [DataWidth-1:0]   w_rx;

  cfg_word_shifter #(.DataWidth(DataWidth)) u_shifter (
    .i_clk      (Clk_i),
    .i_rst_n    (Reset_n_i),
    .i_load     (w_load),
    .i_word     (host.DataIn_i),
    .i_capture  (w_capture),
    .i_cap_bit  (CfgDataIn_i),
    .i_advance  (w_advance),
    .o_next_bit (w_next_bit),
    .o_last     (w_last),
    .o_rx       (w_rx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host.Start_i) w_state_nxt = (host.Length_i == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (host.DataInValid_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        // The edge leaving ShiftLow raises CfgClk_o; the chain has not shifted yet.
        w_capture   = 1'b1;
        w_state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        w_advance   = 1'b1;
        w_state_nxt = (w_last || r_remaining == LengthWidth'(1)) ? S_FLUSH : S_SHIFT_LO;
      end
      S_FLUSH: begin
        if (host.DataOutReady_i) w_state_nxt = (r_remaining != '0) ? S_FETCH : S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_cfg_mode  <= 1'b0;
      r_cfg_clk   <= 1'b0;
      r_cfg_shift <= 1'b0;
      r_cfg_dout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && host.Start_i) r_remaining <= host.Length_i;
      else if (w_advance)                    r_remaining <= r_remaining - LengthWidth'(1);
      // Cfg outputs are registered from the next state so they change with the state itself.
      r_cfg_mode  <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_SHIFT_LO) ||
                     (w_state_nxt == S_SHIFT_HI) || (w_state_nxt == S_FLUSH);
      r_cfg_clk   <= (w_state_nxt == S_SHIFT_HI);
      r_cfg_shift <= (w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI);
      if (w_state_nxt == S_SHIFT_LO)      r_cfg_dout <= w_next_bit;
      else if (w_state_nxt != S_SHIFT_HI) r_cfg_dout <= 1'b0;
    end
  end

  assign CfgMode_o    = r_cfg_mode;
  assign CfgClk_o     = r_cfg_clk;
  assign CfgShift_o   = r_cfg_shift;
  assign CfgDataOut_o = r_cfg_dout;

  assign host.DataInReady_o  = (r_state == S_FETCH);
  assign host.DataOutValid_o = (r_state == S_FLUSH);
  assign host.DataOut_o      = w_rx;
  assign host.Busy_o         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign host.Done_o         = (r_state == S_DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomised bench for cfg_chain_loader with a bit-sequence model of the chain and readback.
module tb_cfg_chain_loader;
  import cfg_chain_pkg::*;

  localparam int DW   = 16;
  localparam int LW   = 16;
  localparam int MAXL = 64;
  localparam int MAXN = 100;
  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_chain_loader_if #(.DataWidth(DW), .LengthWidth(LW)) host ();
  logic cfg_mode, cfg_clk, cfg_shift, cfg_dout, cfg_din;

  cfg_chain_loader #(.DataWidth(DW), .LengthWidth(LW)) dut (
    .Clk_i        (clk),
    .Reset_n_i    (rst_n),
    .host         (host),
    .CfgMode_o    (cfg_mode),
    .CfgClk_o     (cfg_clk),
    .CfgShift_o   (cfg_shift),
    .CfgDataOut_o (cfg_dout),
    .CfgDataIn_i  (cfg_din)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Chain of chain_len cells: new bit enters at the far end, cell 0 drives the readback line.
  logic [MAXL-1:0] chain;
  int              chain_len = 16;
  assign cfg_din = chain[0];
  always @(posedge cfg_clk) begin
    if (cfg_shift) begin
      chain = chain >> 1;
      chain[chain_len-1] = cfg_dout;
    end
  end

  // S = initial chain cells followed by the stream; bit k leaving the chain is S[k].
  logic          S [0:MAXL+MAXN-1];
  logic [DW-1:0] words  [0:MAXW-1];
  logic [DW-1:0] exp_rd [0:MAXW-1];
  logic [DW-1:0] rd_got [0:MAXW-1];
  logic [63:0]   exp_chain;

  bit            active = 1'b0;
  int            cur_n, cyc, done_cyc, rise_cnt, rx_cnt;
  logic          p_clk, p_shift, p_dout, p_ovld, p_ordy;
  logic [DW-1:0] p_odat;

  always @(negedge clk) begin
    #1;
    if (active) begin
      cyc++;
      if (cur_n == 0) chk("len0_quiet", 64'({cfg_mode, cfg_clk, host.DataInReady_o}), 64'(0));
      if (cfg_clk) begin
        chk("clk_pulse_low_before", 64'(p_clk), 64'(0));
        if (!p_clk) begin
          chk("bit_val", 64'(cfg_dout),
              64'((rise_cnt < cur_n) ? S[chain_len + rise_cnt] : 1'bx));
          chk("bit_setup", 64'(p_dout), 64'(cfg_dout));
          chk("bit_ctl", 64'({cfg_shift, cfg_mode, p_shift}), 64'(3'b111));
          rise_cnt++;
        end
      end
      if (host.DataInReady_o || host.DataOutValid_o)
        chk("stall_quiet", 64'({cfg_clk, cfg_shift}), 64'(0));
      if (p_ovld && !p_ordy)
        chk("rd_hold", 64'({host.DataOutValid_o, host.DataOut_o}), 64'({1'b1, p_odat}));
      if (host.DataOutValid_o && host.DataOutReady_i) begin
        if (rx_cnt < MAXW) begin
          chk("rd_word", 64'(host.DataOut_o), 64'(exp_rd[rx_cnt]));
          rd_got[rx_cnt] = host.DataOut_o;
        end
        rx_cnt++;
      end
      chk("busy", 64'(host.Busy_o), 64'(!host.Done_o));
      if (host.Done_o) begin
        done_cyc = cyc;
        chk("bits_total", 64'(rise_cnt), 64'(cur_n));
        chk("words_total", 64'(rx_cnt), 64'(ceil_words(cur_n)));
        chk("chain_final", 64'(chain), exp_chain);
        active = 1'b0;
      end
      p_clk   = cfg_clk;
      p_shift = cfg_shift;
      p_dout  = cfg_dout;
      p_ovld  = host.DataOutValid_o;
      p_ordy  = host.DataOutReady_i;
      p_odat  = host.DataOut_o;
    end
  end

  task automatic run_load(input int n, input int l, input logic [63:0] pre,
                          input int vhold, input int rhold, input bit rnd,
                          input bit glitch, input int rst_bit);
    int   nw, widx, fw, rw, k;
    bit   glitched, finished;
    logic vld, rdy;
    nw = int'(ceil_words(n));
    for (int i = 0; i < l; i++) S[i] = pre[i];
    for (int i = 0; i < n; i++) S[l+i] = words[i / DW][i % DW];
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < DW; b++) begin
        k = w * DW + b;
        exp_rd[w][b] = (k < n) ? S[k] : 1'b0;
      end
    exp_chain = '0;
    for (int j = 0; j < l; j++) exp_chain[j] = S[n+j];
    chain_len = l;
    chain = (l == MAXL) ? pre : (pre & ((64'd1 << l) - 64'd1));

    @(negedge clk);
    host.Start_i  = 1'b1;
    host.Length_i = LW'(n);
    cyc = 0; rise_cnt = 0; rx_cnt = 0; done_cyc = -1; cur_n = n;
    p_clk = 0; p_shift = 0; p_dout = 0; p_ovld = 0; p_ordy = 0; p_odat = '0;
    @(posedge clk);
    active = 1'b1;
    widx = 0; fw = 0; rw = 0; glitched = 0; finished = 0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      @(negedge clk);
      host.Start_i = 1'b0;
      if (host.Done_o) begin
        finished = 1'b1;
      end else if (rst_bit >= 0 && rise_cnt >= rst_bit) begin
        active = 1'b0;
        rst_n  = 1'b0;
        host.DataInValid_i  = 1'b0;
        host.DataOutReady_i = 1'b0;
        @(negedge clk);
        #1;
        chk("midload_reset_outs",
            64'({cfg_mode, cfg_clk, cfg_shift, cfg_dout, host.DataInReady_o,
                 host.DataOutValid_o, host.Busy_o, host.Done_o, host.DataOut_o}), 64'(0));
        rst_n = 1'b1;
        return;
      end else begin
        fw = host.DataInReady_o ? fw + 1 : 0;
        rw = host.DataOutValid_o ? rw + 1 : 0;
        vld = (widx < nw) && (rnd ? ($urandom_range(0, 2) != 0) : (fw > vhold));
        host.DataInValid_i = vld;
        host.DataIn_i = (widx < nw) ? words[widx] : DW'($urandom);
        if (vld && host.DataInReady_o) widx++;
        rdy = rnd ? ($urandom_range(0, 2) != 0) : (rw > rhold);
        host.DataOutReady_i = rdy;
        if (glitch && !glitched && cfg_clk && rise_cnt >= 5) begin
          host.Start_i  = 1'b1;
          host.Length_i = LW'($urandom_range(1, 200));
          glitched = 1'b1;
        end
      end
    end
    #2;
    chk("done_reached", 64'(host.Done_o), 64'(1));
    active = 1'b0;
    if (!rnd && vhold == 0 && rhold == 0)
      chk("done_cycle", 64'(done_cyc), 64'(1 + 2 * n + 2 * nw));
    host.DataInValid_i  = 1'b0;
    host.DataOutReady_i = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after", 64'({host.Busy_o, host.Done_o, cfg_mode, host.DataInReady_o}), 64'(0));
  endtask

  initial begin
    int          n, l;
    logic [63:0] pre;
    host.Start_i = 0; host.Length_i = '0; host.DataIn_i = '0;
    host.DataInValid_i = 0; host.DataOutReady_i = 0;
    chain = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs",
        64'({cfg_mode, cfg_clk, cfg_shift, cfg_dout, host.DataInReady_o,
             host.DataOutValid_o, host.Busy_o, host.Done_o, host.DataOut_o}), 64'(0));
    rst_n = 1'b1;

    words[0] = 16'hA5C3;
    run_load(16, 16, 64'h1234, 0, 0, 0, 0, -1);
    chk("t16_chain", 64'(chain), 64'h0000_0000_0000_A5C3);
    chk("t16_readback", 64'(rd_got[0]), 64'h1234);
    chk("t16_done_cycle", 64'(done_cyc), 64'd35);

    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h00AB;
    run_load(40, 40, 64'h12_3456_789A, 0, 0, 0, 0, -1);
    chk("t40_words", 64'(rx_cnt), 64'd3);
    chk("t40_rd0", 64'(rd_got[0]), 64'h789A);
    chk("t40_rd1", 64'(rd_got[1]), 64'h3456);
    chk("t40_rd2", 64'(rd_got[2]), 64'h0012);
    chk("t40_chain", 64'(chain), 64'h00_0000_00AB_0000_FFFF);

    run_load(0, 8, 64'h5A, 0, 0, 0, 0, -1);
    chk("t0_done_cycle", 64'(done_cyc), 64'd1);
    chk("t0_chain_untouched", 64'(chain), 64'h5A);

    words[0] = 16'hA5C3;
    run_load(16, 16, 64'h1234, 5, 7, 0, 0, -1);
    chk("stall_chain", 64'(chain), 64'h0000_0000_0000_A5C3);
    chk("stall_readback", 64'(rd_got[0]), 64'h1234);

    words[0] = 16'h3C96;
    run_load(16, 16, 64'hBEEF, 0, 0, 0, 0, 9);
    words[0] = 16'h0F0F;
    run_load(16, 16, 64'hC001, 0, 0, 0, 0, -1);
    chk("after_reset_chain", 64'(chain), 64'h0F0F);
    chk("after_reset_readback", 64'(rd_got[0]), 64'hC001);

    words[0] = 16'h1357; words[1] = 16'h2468; words[2] = 16'h9ACE;
    run_load(40, 40, 64'h0, 0, 0, 0, 1, -1);
    chk("glitch_chain", 64'(chain), 64'h00_0000_00CE_2468_1357);

    for (int t = 0; t < 20; t++) begin
      n   = $urandom_range(1, MAXN);
      l   = $urandom_range(1, MAXL);
      pre = {$urandom, $urandom};
      for (int w = 0; w < MAXW; w++) words[w] = DW'($urandom);
      run_load(n, l, pre, 0, 0, t[0], 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
